serial_pattern_gen: RTL and testbench
=====================================

// Module: serial_pattern_gen
// PURPOSE
//  Serial bit-stream transmitter: the sending end of the single-bit serial line our
//  sequence-detector FSMs consume. Captures a WIDTH-bit pattern on start and shifts it
//  out MSB-first, one bit per clk, optionally repeated with idle gaps between frames.
//  Drives the detector's serial input in system benches; exposes its state for waveform debug.
// PARAMETERS
//  WIDTH     8  pattern length in bits (>=2)
//  GAP_CYC   2  idle cycles inserted between repeated frames (0 = back-to-back)
//  IDLE_LVL  0  level driven on sout when not transmitting a pattern bit
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst         in   1      synchronous reset, active-high
//  start       in   1      request transmission; sampled only in IDLE
//  pattern     in   WIDTH  frame to send, captured at accepted start
//  repeat_cnt  in   8      frames to send; 0 treated as 1
//  sout        out  1      serial data out (registered)
//  busy        out  1      high in SHIFT and GAP
//  done        out  1      one-cycle pulse after final frame
//  state       out  3      current FSM state encoding
// BEHAVIOUR
//  - Interface: one clock clk; rst synchronous, active-high, sampled on rising edge of clk.
//  - Reset: sout=IDLE_LVL, busy=0, done=0, state=IDLE; all counters and shadow regs cleared.
//  - Encoding: IDLE=3'b000, SHIFT=3'b001, GAP=3'b010, DONE=3'b011; others -> IDLE next edge.
//  - All outputs registered; values below are those visible after the named edge.
//  - IDLE: sout=IDLE_LVL, busy=0. Edge N with start=1: shadow<=pattern,
//    reps<=(repeat_cnt==0 ? 1 : repeat_cnt); state->SHIFT; sout<=pattern[WIDTH-1]; busy<=1.
//  - SHIFT: bit k (MSB first) held exactly one cycle; frame occupies WIDTH cycles after
//    edges N..N+WIDTH-1. Bit index counter $clog2(WIDTH) bits, no wrap beyond WIDTH-1.
//  - End of frame, reps remaining >1: reps--; GAP_CYC>0 -> GAP for GAP_CYC cycles with
//    sout=IDLE_LVL, busy=1, then SHIFT from MSB; GAP_CYC=0 -> next frame MSB on very next cycle.
//  - End of final frame: state->DONE; done=1, busy=0, sout=IDLE_LVL for one cycle; then IDLE.
//  - Total busy cycles = reps*WIDTH + (reps-1)*GAP_CYC; reps=255 must not overflow counters.
//  - start ignored in SHIFT, GAP, DONE (no queueing); earliest re-accept is first IDLE cycle.
//  - pattern/repeat_cnt changes after acceptance have no effect on the transmission.
//  - rst mid-operation: next edge all outputs to reset values, no done pulse, frame aborted.
//  - rst and start both high on same edge: rst wins, start dropped.
//  - done and busy never high together; sout never X after reset.
// TESTING (WIDTH=8, GAP_CYC=2, IDLE_LVL=0 unless noted)
//  1. rst high 2 cycles -> sout=0, busy=0, done=0, state=000; stays idle with start=0.
//  2. start 1 cycle, pattern=8'b1011_0010, repeat_cnt=1 -> sout 1,0,1,1,0,0,1,0 on 8 cycles,
//     busy=1 those 8 cycles, done=1 on 9th cycle only, then state=000.
//  3. repeat_cnt=3 -> 3 frames split by 2 zero cycles; busy 28 cycles; exactly one done pulse.
//  4. repeat_cnt=0 -> identical to scenario 2; GAP_CYC=0 build, repeat_cnt=2 -> 16 bits no gap.
//  5. start re-pulsed and pattern=8'hFF mid-frame -> ignored; sout sequence of scenario 2 intact.
//  6. rst at 4th bit -> next cycle sout=0, busy=0, state=000, no done; new start then sends cleanly.

Source files
------------

// File: rtl/serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pattern_gen
//  Description : Serial bit-stream transmitter. Captures a WIDTH-bit pattern
//                when start is accepted in IDLE. Shifts it out MSB-first on
//                sout, one bit per clock. Optionally repeats the frame, with
//                GAP_CYC idle cycles between frames. Exposes its FSM state
//                for waveform debug.
//
//  Ports
//    clk         in   1      clock, all logic on the rising edge
//    rst         in   1      synchronous reset, active-high
//    start       in   1      transmission request, sampled only in IDLE
//    pattern     in   WIDTH  frame to send, captured when start is accepted
//    repeat_cnt  in   8      number of frames to send (0 is treated as 1)
//    sout        out  1      serial data out (registered)
//    busy        out  1      high while in SHIFT or GAP
//    done        out  1      one-cycle pulse after the final frame
//    state       out  3      current FSM state encoding
//
//  Revision    : 1.0  initial release
// ============================================================================
module serial_pattern_gen #(
    parameter int WIDTH    = 8,
    parameter int GAP_CYC  = 2,
    parameter bit IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [7:0]       repeat_cnt,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int IW = $clog2(WIDTH);
    // The gap counter needs at least one bit, even when GAP_CYC is 0 or 1.
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [IW-1:0] c_LAST_IDX = IW'(WIDTH - 1);
    localparam logic [GW-1:0] c_GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;
    localparam bit            c_HAS_GAP  = (GAP_CYC > 0);

    // FSM state encoding
    localparam logic [2:0] c_IDLE  = 3'b000;
    localparam logic [2:0] c_SHIFT = 3'b001;
    localparam logic [2:0] c_GAP   = 3'b010;
    localparam logic [2:0] c_DONE  = 3'b011;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [2:0]       r_state;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_shadow;   // pattern as captured, reloaded for each frame
    logic [WIDTH-1:0] r_shift;    // bits of the current frame still to be sent
    logic [7:0]       r_reps;     // frames remaining, including the current one
    logic [IW-1:0]    r_idx;      // index of the bit currently on sout (0 = MSB)
    logic [GW-1:0]    r_gap;      // idle cycles already spent in the current gap

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [2:0]       w_state;
    logic             w_sout;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_shadow;
    logic [WIDTH-1:0] w_shift;
    logic [7:0]       w_reps;
    logic [IW-1:0]    w_idx;
    logic [GW-1:0]    w_gap;

    always_comb begin
        w_state  = r_state;
        w_sout   = r_sout;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_shadow = r_shadow;
        w_shift  = r_shift;
        w_reps   = r_reps;
        w_idx    = r_idx;
        w_gap    = r_gap;

        case (r_state)
            c_IDLE: begin
                w_sout = IDLE_LVL;
                w_busy = 1'b0;
                if (start) begin
                    // The MSB goes straight to sout on the accepting edge.
                    // The remaining bits are left-aligned in the shifter.
                    w_shadow = pattern;
                    w_shift  = pattern << 1;
                    w_reps   = (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
                    w_idx    = '0;
                    w_gap    = '0;
                    w_state  = c_SHIFT;
                    w_sout   = pattern[WIDTH-1];
                    w_busy   = 1'b1;
                end
            end

            c_SHIFT: begin
                if (r_idx == c_LAST_IDX) begin
                    if (r_reps > 8'd1) begin
                        w_reps = r_reps - 8'd1;
                        if (c_HAS_GAP) begin
                            w_state = c_GAP;
                            w_sout  = IDLE_LVL;
                            w_gap   = '0;
                        end else begin
                            // No gap: the next frame's MSB follows immediately.
                            w_state = c_SHIFT;
                            w_sout  = r_shadow[WIDTH-1];
                            w_shift = r_shadow << 1;
                            w_idx   = '0;
                        end
                    end else begin
                        w_state = c_DONE;
                        w_sout  = IDLE_LVL;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_reps  = 8'd0;
                    end
                end else begin
                    w_idx   = r_idx + 1'b1;
                    w_sout  = r_shift[WIDTH-1];
                    w_shift = r_shift << 1;
                end
            end

            c_GAP: begin
                // busy stays high through the gap; sout rests at the idle level.
                w_sout = IDLE_LVL;
                if (r_gap == c_GAP_LAST) begin
                    w_state = c_SHIFT;
                    w_sout  = r_shadow[WIDTH-1];
                    w_shift = r_shadow << 1;
                    w_idx   = '0;
                    w_gap   = '0;
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end

            c_DONE: begin
                // The done pulse lasts exactly one cycle.
                // start is not sampled here.
                w_state = c_IDLE;
                w_sout  = IDLE_LVL;
                w_busy  = 1'b0;
            end

            default: begin
                // Unused encodings recover to a clean IDLE.
                w_state  = c_IDLE;
                w_sout   = IDLE_LVL;
                w_busy   = 1'b0;
                w_shadow = '0;
                w_shift  = '0;
                w_reps   = 8'd0;
                w_idx    = '0;
                w_gap    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_sout   <= IDLE_LVL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_shadow <= '0;
            r_shift  <= '0;
            r_reps   <= 8'd0;
            r_idx    <= '0;
            r_gap    <= '0;
        end else begin
            r_state  <= w_state;
            r_sout   <= w_sout;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_shadow <= w_shadow;
            r_shift  <= w_shift;
            r_reps   <= w_reps;
            r_idx    <= w_idx;
            r_gap    <= w_gap;
        end
    end

    assign sout  = r_sout;
    assign busy  = r_busy;
    assign done  = r_done;
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_pattern_gen
//  Description : Self-checking bench for serial_pattern_gen.
//                dut_g  : WIDTH=8, GAP_CYC=2, IDLE_LVL=0
//                dut_ng : WIDTH=8, GAP_CYC=0, IDLE_LVL=0
//                The expected waveforms come from a per-cycle list of
//                (sout, busy, done, state). The list is built directly from
//                the frame/gap/done rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_g,  start_ng;
    logic [7:0] pattern_g, pattern_ng;
    logic [7:0] rcnt_g,   rcnt_ng;
    logic       sout_g,   sout_ng;
    logic       busy_g,   busy_ng;
    logic       done_g,   done_ng;
    logic [2:0] state_g,  state_ng;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_pattern_gen #(.WIDTH(8), .GAP_CYC(2), .IDLE_LVL(1'b0)) dut_g (
        .clk(clk), .rst(rst), .start(start_g), .pattern(pattern_g),
        .repeat_cnt(rcnt_g), .sout(sout_g), .busy(busy_g), .done(done_g),
        .state(state_g)
    );

    serial_pattern_gen #(.WIDTH(8), .GAP_CYC(0), .IDLE_LVL(1'b0)) dut_ng (
        .clk(clk), .rst(rst), .start(start_ng), .pattern(pattern_ng),
        .repeat_cnt(rcnt_ng), .sout(sout_ng), .busy(busy_ng), .done(done_ng),
        .state(state_ng)
    );

    typedef struct {
        logic [7:0] pat;
        logic [7:0] rc;
        int         which;     // 0: dut_g, 1: dut_ng
        bit         glitch;    // re-pulse start and change inputs mid-frame
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic sample(input int which, output logic s, output logic b,
                          output logic d, output logic [2:0] st);
        if (which == 0) begin
            s = sout_g; b = busy_g; d = done_g; st = state_g;
        end else begin
            s = sout_ng; b = busy_ng; d = done_ng; st = state_ng;
        end
    endtask

    task automatic check_idle(input int which, input string tag);
        logic s, b, d;
        logic [2:0] st;
        sample(which, s, b, d, st);
        chk({tag, "_sout"},  {15'd0, s}, 16'd0);
        chk({tag, "_busy"},  {15'd0, b}, 16'd0);
        chk({tag, "_done"},  {15'd0, d}, 16'd0);
        chk({tag, "_state"}, {13'd0, st}, 16'd0);
    endtask

    // Sends one transmission and checks it cycle by cycle against the
    // reference list. The caller must be 1 time unit after a posedge,
    // with the DUT idle.
    task automatic send(input int which, input logic [7:0] pat, input logic [7:0] rc,
                        input bit glitch, input int exp_busy);
        logic       q_s[$];
        logic       q_b[$];
        logic       q_d[$];
        logic [2:0] q_st[$];
        int reps, gap, busy_cnt, done_cnt;
        logic s, b, d;
        logic [2:0] st;
        gap  = (which == 0) ? 2 : 0;
        reps = (rc == 8'd0) ? 1 : int'(rc);
        for (int f = 0; f < reps; f++) begin
            for (int k = 7; k >= 0; k--) begin
                q_s.push_back(pat[k]); q_b.push_back(1'b1);
                q_d.push_back(1'b0);   q_st.push_back(3'b001);
            end
            if (f < reps - 1) begin
                for (int g = 0; g < gap; g++) begin
                    q_s.push_back(1'b0); q_b.push_back(1'b1);
                    q_d.push_back(1'b0); q_st.push_back(3'b010);
                end
            end
        end
        q_s.push_back(1'b0); q_b.push_back(1'b0);
        q_d.push_back(1'b1); q_st.push_back(3'b011);

        if (which == 0) begin
            start_g = 1'b1; pattern_g = pat; rcnt_g = rc;
        end else begin
            start_ng = 1'b1; pattern_ng = pat; rcnt_ng = rc;
        end
        tick();
        start_g = 1'b0; start_ng = 1'b0;

        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < q_s.size(); i++) begin
            sample(which, s, b, d, st);
            chk("seq_sout",  {15'd0, s},  {15'd0, q_s[i]});
            chk("seq_busy",  {15'd0, b},  {15'd0, q_b[i]});
            chk("seq_done",  {15'd0, d},  {15'd0, q_d[i]});
            chk("seq_state", {13'd0, st}, {13'd0, q_st[i]});
            if (b === 1'b1 && d === 1'b1) chk("busy_and_done", 16'd1, 16'd0);
            if (b === 1'b1) busy_cnt++;
            if (d === 1'b1) done_cnt++;
            if (glitch && i == 3) begin
                // A start pulse and new inputs arrive mid-frame.
                // They must be ignored.
                if (which == 0) begin
                    start_g = 1'b1; pattern_g = 8'hFF; rcnt_g = 8'd7;
                end else begin
                    start_ng = 1'b1; pattern_ng = 8'hFF; rcnt_ng = 8'd7;
                end
            end
            if (glitch && i == 4) begin
                start_g = 1'b0; start_ng = 1'b0;
            end
            tick();
        end
        check_idle(which, "post_idle");
        chk("busy_cycles", 16'(busy_cnt), 16'(exp_busy));
        chk("done_pulses", 16'(done_cnt), 16'd1);
    endtask

    initial begin
        vecs[0] = '{8'b1011_0010, 8'd1, 0, 1'b0, 8};
        vecs[1] = '{8'b1011_0010, 8'd3, 0, 1'b0, 28};
        vecs[2] = '{8'b1011_0010, 8'd0, 0, 1'b0, 8};
        vecs[3] = '{8'b1011_0010, 8'd2, 1, 1'b0, 16};
        vecs[4] = '{8'b1011_0010, 8'd1, 0, 1'b1, 8};
        vecs[5] = '{8'b0100_1101, 8'd2, 0, 1'b0, 18};

        rst = 1'b1;
        start_g = 1'b0; start_ng = 1'b0;
        pattern_g = 8'h00; pattern_ng = 8'h00;
        rcnt_g = 8'd0; rcnt_ng = 8'd0;
        tick();
        tick();
        check_idle(0, "reset_g");
        check_idle(1, "reset_ng");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle(0, "idle_hold");
        end

        // Directed vectors
        foreach (vecs[v]) begin
            send(vecs[v].which, vecs[v].pat, vecs[v].rc, vecs[v].glitch, vecs[v].exp_busy);
        end

        // rst during the 4th bit aborts the frame: no done pulse.
        start_g = 1'b1; pattern_g = 8'b1011_0010; rcnt_g = 8'd1;
        tick();
        start_g = 1'b0;
        chk("abort_bit0", {15'd0, sout_g}, 16'd1);
        tick();
        chk("abort_bit1", {15'd0, sout_g}, 16'd0);
        tick();
        chk("abort_bit2", {15'd0, sout_g}, 16'd1);
        tick();
        chk("abort_bit3", {15'd0, sout_g}, 16'd1);
        rst = 1'b1;
        tick();
        check_idle(0, "abort_rst");
        rst = 1'b0;
        tick();
        check_idle(0, "abort_after");
        tick();
        check_idle(0, "abort_after2");
        send(0, 8'b1011_0010, 8'd1, 1'b0, 8);

        // rst and start on the same edge: rst wins and start is dropped.
        rst = 1'b1; start_g = 1'b1; pattern_g = 8'hA5; rcnt_g = 8'd1;
        tick();
        check_idle(0, "rst_vs_start");
        rst = 1'b0; start_g = 1'b0;
        tick();
        check_idle(0, "rst_vs_start_after");

        // Maximum repeat count
        send(0, 8'hC3, 8'd255, 1'b0, 255 * 8 + 254 * 2);

        // Randomized transmissions
        for (int r = 0; r < 24; r++) begin
            int   which;
            int   reps;
            logic [7:0] pat;
            logic [7:0] rc;
            bit   gl;
            which = int'($urandom_range(0, 1));
            pat   = 8'($urandom);
            rc    = 8'($urandom_range(0, 5));
            gl    = 1'($urandom_range(0, 1));
            reps  = (rc == 8'd0) ? 1 : int'(rc);
            send(which, pat, rc, gl, reps * 8 + (reps - 1) * ((which == 0) ? 2 : 0));
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
